// File: rtl/pipelined_adder_pkg.sv
// Shared constants and helpers for the pipelined adder/subtractor.
// Default geometry splits a 32-bit carry chain into four registered slices.
package pipelined_adder_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;

  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction

  // Legal geometry: 1..width slices that tile the word exactly.
  function automatic bit split_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_addsub_slice.sv
// Combinational W-bit ripple-carry slice; also exposes the carry into its top bit
// so the final slice can form the signed-overflow flag.
module adder_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb_in
);

  logic carry;

  always_comb begin
    carry    = cin;
    c_msb_in = cin;
    sum      = '0;
    for (int i = 0; i < W; i++) begin
      c_msb_in = carry;
      sum[i]   = a[i] ^ b[i] ^ carry;
      carry    = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: STAGES registered ripple slices,
// valid/ready at both ends, one global enable stalls the whole pipe on backpressure.
module pipelined_addsub
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int W_S = slice_width(WIDTH, STAGES);

  if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
    $error("pipelined_addsub: WIDTH must be a multiple of STAGES");
  end

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign b_eff = sub ? ~b : b;
  assign c0    = sub ? 1'b1 : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_in, b_in, s_in;
    logic             c_in, v_in;
    logic [W_S-1:0]   sl_sum;
    logic             sl_cout, sl_cmsb;

    logic [WIDTH-1:0] sum_d, sum_q, opa_d, opa_q, opb_d, opb_q;
    logic             carry_d, carry_q, valid_d, valid_q, ovf_d, ovf_q;

    if (k == 0) begin : g_first
      assign a_in = a;
      assign b_in = b_eff;
      assign s_in = '0;
      assign c_in = c0;
      assign v_in = in_valid;
    end else begin : g_next
      assign a_in = g_stage[k-1].opa_q;
      assign b_in = g_stage[k-1].opb_q;
      assign s_in = g_stage[k-1].sum_q;
      assign c_in = g_stage[k-1].carry_q;
      assign v_in = g_stage[k-1].valid_q;
    end

    adder_slice #(.W(W_S)) u_slice (
      .a        (a_in[k*W_S +: W_S]),
      .b        (b_in[k*W_S +: W_S]),
      .cin      (c_in),
      .sum      (sl_sum),
      .cout     (sl_cout),
      .c_msb_in (sl_cmsb)
    );

    // Lower result slices pass through; this stage fills in its own slice.
    always_comb begin
      sum_d                = s_in;
      sum_d[k*W_S +: W_S]  = sl_sum;
      carry_d              = sl_cout;
      valid_d              = v_in;
      opa_d                = a_in;
      opb_d                = b_in;
      ovf_d                = sl_cmsb ^ sl_cout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q   <= '0;
        opa_q   <= '0;
        opb_q   <= '0;
        carry_q <= 1'b0;
        valid_q <= 1'b0;
        ovf_q   <= 1'b0;
      end else if (en) begin
        sum_q   <= sum_d;
        opa_q   <= opa_d;
        opb_q   <= opb_d;
        carry_q <= carry_d;
        valid_q <= valid_d;
        ovf_q   <= ovf_d;
      end
    end
  end

  assign en        = !g_stage[STAGES-1].valid_q || out_ready;
  assign in_ready  = en;
  assign out_valid = g_stage[STAGES-1].valid_q;
  assign sum       = g_stage[STAGES-1].sum_q;
  assign cout      = g_stage[STAGES-1].carry_q;
  assign ovf       = g_stage[STAGES-1].ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub (WIDTH=32, STAGES=4): directed corner
// cases, backpressure stream and reset scenarios against an arithmetic model.
module tb_pipelined_addsub;
  import pipelined_adder_pkg::*;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  typedef logic [WIDTH+1:0] res_t;   // {ovf, cout, sum}

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  res_t sb[$];

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                 input logic mcin, input logic msub);
    logic [WIDTH-1:0] be;
    logic [WIDTH:0]   full;
    logic             v;
    be   = msub ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, be} + {{WIDTH{1'b0}}, (msub ? 1'b1 : mcin)};
    v    = (ma[WIDTH-1] == be[WIDTH-1]) && (full[WIDTH-1] != ma[WIDTH-1]);
    return {v, full[WIDTH], full[WIDTH-1:0]};
  endfunction

  // Handshakes evaluated on the falling edge: inputs are stable until the next rising edge.
  always @(negedge clk) begin
    res_t e;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          check("sb_spurious_out", 1, 0);
        end else begin
          e = sb.pop_front();
          check("sb_sum",  sum,  e[WIDTH-1:0]);
          check("sb_cout", cout, e[WIDTH]);
          check("sb_ovf",  ovf,  e[WIDTH+1]);
        end
      end
      if (in_valid && in_ready) sb.push_back(model(a, b, cin, sub));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_one(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                          input logic tcin, input logic tsub,
                          input logic [WIDTH-1:0] esum, input logic ecout,
                          input logic eovf, input string tag);
    int n;
    a = ta; b = tb_v; cin = tcin; sub = tsub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, STAGES);
    check({tag, "_sum"}, sum, esum);
    check({tag, "_cout"}, cout, ecout);
    check({tag, "_ovf"}, ovf, eovf);
  endtask

  task automatic wait_drain(input string tag);
    int g;
    g = 0;
    while (sb.size() != 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_drained"}, sb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int               base;
    int               g;
    logic             acc;
    logic [WIDTH-1:0] held;

    // Reset held with random stimulus
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      a = $urandom; b = $urandom;
      cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_sum", sum, 0);
      check("rst_cout_ovf", {cout, ovf}, 0);
    end
    @(negedge clk); #2;
    in_valid = 1'b0; out_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    @(posedge clk); #1;

    // Directed corner cases
    send_one(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, "add_wrap");
    send_one(32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_borrow");
    send_one(32'd7, 32'd5, 1'b0, 1'b1, 32'd2, 1'b1, 1'b0, "sub_noborrow");
    send_one(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "ovf_add");
    send_one(32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "ovf_sub");
    send_one(32'h0000_00FF, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0101, 1'b0, 1'b0, "add_cin");
    wait_drain("directed");

    // Backpressure: 8 back-to-back beats, out_ready low for 3 cycles mid-stream
    base = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          a = $urandom; b = $urandom;
          cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
          in_valid = 1'b1;
          g = 0;
          do begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
            g++;
          end while (!acc && g < 20);
          check("bp_accept_bound", acc, 1);
        end
        in_valid = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        held = sum;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          check("stall_in_ready", in_ready, 0);
          check("stall_out_valid", out_valid, 1);
          check("stall_sum_held", sum, held);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
        g = 0;
        while (sb.size() != 0 && g < 30) begin
          @(negedge clk);
          if (sb.size() != 0) check("tput_out_valid", out_valid, 1);
          @(posedge clk); #1;
          g++;
        end
      end
    join
    wait_drain("backpressure");
    check("bp_beat_count", n_out - base, 8);

    // Reset while output is stalled: outputs clear immediately
    out_ready = 1'b0;
    a = 32'hFFFF_FFFF; b = 32'h2; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    g = 0;
    while (!out_valid && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    check("stall_rst_pre_valid", out_valid, 1);
    check("stall_rst_pre_sum", sum, 32'h1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("stall_rst_out_valid", out_valid, 0);
    check("stall_rst_sum", sum, 0);
    check("stall_rst_cout", cout, 0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Reset mid-flight: three beats accepted, none may emerge
    base = n_out;
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_no_stale", out_valid, 0);
    end
    check("midrst_beat_count", n_out - base, 0);
    @(posedge clk); #1;
    send_one(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0, "post_rst");
    wait_drain("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
